// File: rtl/fp_add_sequencer.sv
// Multi-cycle IEEE-754 single-precision adder: one operand pair at a time,
// serial alignment and normalisation shifts, truncating rounding.
module fp_add_sequencer #(
  parameter int ALIGN_LIMIT = 25
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        busy
);
  typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_ALIGN, S_ADD, S_NORM, S_DONE} state_t;

  localparam logic [31:0] LIMIT = ALIGN_LIMIT;

  state_t      r_state, w_next;
  logic        r_in_ready;
  logic [31:0] r_a, r_b, r_result;
  logic        r_sign_big, r_sign_small, r_sign;
  logic [7:0]  r_exp, r_d;
  logic [23:0] r_mant_big, r_mant_small;
  logic [24:0] r_sum;

  logic [7:0]  w_ea, w_eb, w_d, w_exp_up, w_exp_dn;
  logic [23:0] w_ma, w_mb;
  logic        w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_special, w_a_big, w_far;
  logic [31:0] w_special_val;
  logic [24:0] w_add_sum, w_sum_l, w_sum_r;
  logic        w_add_sign, w_add_done;

  function automatic logic [31:0] f_pack(input logic s, input logic [7:0] e, input logic [22:0] m);
    return {s, e, m};
  endfunction

  // Unpack of the captured operands
  assign w_ea    = r_a[30:23];
  assign w_eb    = r_b[30:23];
  assign w_ma    = (w_ea != 8'd0) ? {1'b1, r_a[22:0]} : 24'd0;
  assign w_mb    = (w_eb != 8'd0) ? {1'b1, r_b[22:0]} : 24'd0;
  assign w_a_nan = (w_ea == 8'hFF) && (r_a[22:0] != 23'd0);
  assign w_b_nan = (w_eb == 8'hFF) && (r_b[22:0] != 23'd0);
  assign w_a_inf = (w_ea == 8'hFF) && (r_a[22:0] == 23'd0);
  assign w_b_inf = (w_eb == 8'hFF) && (r_b[22:0] == 23'd0);
  assign w_special = w_a_nan || w_b_nan || w_a_inf || w_b_inf;
  assign w_special_val = (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (r_a[31] != r_b[31])))
                         ? 32'h7FC0_0000 : (w_a_inf ? r_a : r_b);
  assign w_a_big = (w_ea >= w_eb);
  assign w_d     = w_a_big ? (w_ea - w_eb) : (w_eb - w_ea);
  assign w_far   = ({24'd0, w_d} >= LIMIT);

  // Signed-magnitude add; exact cancellation yields +0
  always_comb begin
    w_add_sum  = 25'd0;
    w_add_sign = 1'b0;
    if (r_sign_big == r_sign_small) begin
      w_add_sum  = {1'b0, r_mant_big} + {1'b0, r_mant_small};
      w_add_sign = r_sign_big;
    end else if (r_mant_big > r_mant_small) begin
      w_add_sum  = {1'b0, r_mant_big} - {1'b0, r_mant_small};
      w_add_sign = r_sign_big;
    end else if (r_mant_small > r_mant_big) begin
      w_add_sum  = {1'b0, r_mant_small} - {1'b0, r_mant_big};
      w_add_sign = r_sign_small;
    end
  end

  assign w_add_done = (w_add_sum == 25'd0) || (w_add_sum[24:23] == 2'b01);
  assign w_exp_up   = r_exp + 8'd1;
  assign w_exp_dn   = r_exp - 8'd1;
  assign w_sum_l    = {r_sum[23:0], 1'b0};
  assign w_sum_r    = {1'b0, r_sum[24:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_in_ready <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_in_ready <= (w_next == S_IDLE);
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (in_valid && r_in_ready) w_next = S_UNPACK;
      S_UNPACK: begin
        if (w_special)                     w_next = S_DONE;
        else if (!w_far && w_d != 8'd0)    w_next = S_ALIGN;
        else                               w_next = S_ADD;
      end
      S_ALIGN:  if (r_d <= 8'd1) w_next = S_ADD;
      S_ADD:    w_next = w_add_done ? S_DONE : S_NORM;
      S_NORM: begin
        if (r_sum[24] || r_exp <= 8'd1 || w_sum_l[23]) w_next = S_DONE;
      end
      S_DONE:   if (out_ready) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = r_in_ready;
    out_valid = (r_state == S_DONE);
    busy      = (r_state != S_IDLE);
    result    = r_result;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a          <= 32'd0;
      r_b          <= 32'd0;
      r_result     <= 32'd0;
      r_sign_big   <= 1'b0;
      r_sign_small <= 1'b0;
      r_sign       <= 1'b0;
      r_exp        <= 8'd0;
      r_d          <= 8'd0;
      r_mant_big   <= 24'd0;
      r_mant_small <= 24'd0;
      r_sum        <= 25'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_a <= a;
            r_b <= b;
          end
        end
        S_UNPACK: begin
          r_sign_big   <= w_a_big ? r_a[31] : r_b[31];
          r_sign_small <= w_a_big ? r_b[31] : r_a[31];
          r_exp        <= w_a_big ? w_ea : w_eb;
          r_mant_big   <= w_a_big ? w_ma : w_mb;
          r_mant_small <= w_far ? 24'd0 : (w_a_big ? w_mb : w_ma);
          r_d          <= w_d;
          if (w_special) r_result <= w_special_val;
        end
        S_ALIGN: begin
          r_mant_small <= {1'b0, r_mant_small[23:1]};
          r_d          <= r_d - 8'd1;
        end
        S_ADD: begin
          r_sum  <= w_add_sum;
          r_sign <= w_add_sign;
          if (w_add_sum == 25'd0)  r_result <= {w_add_sign, 31'd0};
          else if (w_add_done)     r_result <= f_pack(w_add_sign, r_exp, w_add_sum[22:0]);
        end
        S_NORM: begin
          if (r_sum[24]) begin
            r_sum    <= w_sum_r;
            r_exp    <= w_exp_up;
            r_result <= (w_exp_up == 8'hFF) ? f_pack(r_sign, 8'hFF, 23'd0)
                                            : f_pack(r_sign, w_exp_up, w_sum_r[22:0]);
          end else if (r_exp <= 8'd1) begin
            r_result <= 32'd0;
          end else begin
            r_sum <= w_sum_l;
            r_exp <= w_exp_dn;
            if (w_sum_l[23]) r_result <= f_pack(r_sign, w_exp_dn, w_sum_l[22:0]);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_add_sequencer.sv
// Randomised and directed bench for fp_add_sequencer against an arithmetic
// reference model of the truncating sequential adder.
module tb_fp_add_sequencer;
  localparam int ALIGN_LIMIT = 25;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        in_ready, out_valid, busy;
  logic [31:0] result;

  int n_total = 0;
  int n_bad   = 0;

  fp_add_sequencer #(.ALIGN_LIMIT(ALIGN_LIMIT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_total++;
    if (got !== expv) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, expv);
    end
  endtask

  // Reference: integer arithmetic on mantissas, latency from counted shifts
  function automatic void ref_model(input logic [31:0] fa, input logic [31:0] fb,
                                    output logic [31:0] res, output int lat);
    int ea, eb, ma, mb, ebig, d, mbig, msm, s, mag, k;
    bit sbig, ssm, sgn, na, nb, ia, ib;
    ea = int'(fa[30:23]);
    eb = int'(fb[30:23]);
    na = (ea == 255) && (fa[22:0] != 23'd0);
    nb = (eb == 255) && (fb[22:0] != 23'd0);
    ia = (ea == 255) && (fa[22:0] == 23'd0);
    ib = (eb == 255) && (fb[22:0] == 23'd0);
    lat = 1;
    if (na || nb || (ia && ib && fa[31] != fb[31])) begin res = 32'h7FC00000; return; end
    if (ia) begin res = fa; return; end
    if (ib) begin res = fb; return; end
    ma = (ea == 0) ? 0 : ((1 << 23) | int'(fa[22:0]));
    mb = (eb == 0) ? 0 : ((1 << 23) | int'(fb[22:0]));
    if (ea >= eb) begin
      ebig = ea; d = ea - eb; mbig = ma; msm = mb; sbig = fa[31]; ssm = fb[31];
    end else begin
      ebig = eb; d = eb - ea; mbig = mb; msm = ma; sbig = fb[31]; ssm = fa[31];
    end
    lat = 2;
    if (d >= ALIGN_LIMIT) msm = 0;
    else begin msm = msm >> d; lat += d; end
    s = (sbig ? -mbig : mbig) + (ssm ? -msm : msm);
    if (s == 0) begin
      res = (sbig == ssm) ? {sbig, 31'd0} : 32'd0;
      return;
    end
    sgn = (s < 0);
    mag = sgn ? -s : s;
    if (mag >= (1 << 24)) begin
      lat++;
      mag = mag >> 1;
      ebig++;
      res = (ebig == 255) ? {sgn, 8'hFF, 23'd0} : {sgn, ebig[7:0], mag[22:0]};
      return;
    end
    k = 0;
    while (mag < (1 << 23)) begin mag = mag << 1; k++; end
    if (k == 0) res = {sgn, ebig[7:0], mag[22:0]};
    else if (k <= ebig - 1) begin
      lat += k;
      ebig -= k;
      res = {sgn, ebig[7:0], mag[22:0]};
    end else begin
      lat += ebig;
      res = 32'd0;
    end
  endfunction

  task automatic do_op(input logic [31:0] ta, input logic [31:0] tb, input int hold,
                       output logic [31:0] res, output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    chk("in_ready_wait", 32'(in_ready), 32'd1);
    in_valid = 1'b1; a = ta; b = tb;
    @(negedge clk);
    in_valid = 1'b0; a = $urandom; b = $urandom;
    lat = 0;
    while (!out_valid && lat < 400) begin @(negedge clk); lat++; end
    res = result;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; a = $urandom; b = $urandom;
      @(negedge clk);
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_result", result, res);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("release_valid", 32'(out_valid), 32'd0);
    if (hold > 0) begin
      chk("release_busy", 32'(busy), 32'd0);
      chk("release_in_ready", 32'(in_ready), 32'd1);
    end
  endtask

  logic [31:0] r_res, m_res, ra, rb, tmp;
  int          r_lat, m_lat, sel, off, e;

  initial begin
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready_pre", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("rel_in_ready_post", 32'(in_ready), 32'd1);

    do_op(32'h3F800000, 32'h3F800000, 0, r_res, r_lat);
    chk("one_plus_one", r_res, 32'h40000000);
    chk("one_plus_one_lat", 32'(r_lat), 32'd3);
    do_op(32'h3F800000, 32'hBF800000, 0, r_res, r_lat);
    chk("cancel", r_res, 32'h00000000);
    chk("cancel_lat", 32'(r_lat), 32'd2);
    do_op(32'h3F800000, 32'h3F000000, 0, r_res, r_lat);
    chk("d1", r_res, 32'h3FC00000);
    chk("d1_lat", 32'(r_lat), 32'd3);
    do_op(32'h3F800000, 32'h33000000, 0, r_res, r_lat);
    chk("d25", r_res, 32'h3F800000);
    chk("d25_lat", 32'(r_lat), 32'd2);
    do_op(32'h7F800000, 32'hFF800000, 0, r_res, r_lat);
    chk("inf_minus_inf", r_res, 32'h7FC00000);
    chk("inf_minus_inf_lat", 32'(r_lat), 32'd1);
    do_op(32'h7F7FFFFF, 32'h7F7FFFFF, 0, r_res, r_lat);
    chk("overflow", r_res, 32'h7F800000);
    do_op(32'h40400000, 32'hC0000000, 5, r_res, r_lat);
    chk("hold_op", r_res, 32'h3F800000);

    // Abort during ALIGN (d=10)
    while (!in_ready) @(negedge clk);
    in_valid = 1'b1; a = 32'h3F800000; b = 32'h3A800000;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd0);
    chk("abort_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tmp = 32'd0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid) tmp = 32'd1;
    end
    chk("abort_no_output", tmp, 32'd0);
    do_op(32'h3F800000, 32'h3F800000, 0, r_res, r_lat);
    chk("after_abort", r_res, 32'h40000000);
    chk("after_abort_lat", 32'(r_lat), 32'd3);

    for (int t = 0; t < 300; t++) begin
      ra = $urandom;
      rb = $urandom;
      sel = int'($urandom_range(0, 9));
      if (sel == 1) begin
        ra[30:23] = 8'hFF;
        if ($urandom_range(0, 1) == 1) ra[22:0] = 23'd0;
      end else if (sel >= 2) begin
        ra[30:23] = 8'($urandom_range(1, 254));
        if (sel == 9) ra[30:23] = 8'($urandom_range(1, 4));
        off = int'($urandom_range(0, 28));
        e = int'(ra[30:23]) - off;
        if (e < 0) e = 0;
        rb[30:23] = 8'(e);
        if (sel >= 7) begin
          rb[30:23] = ra[30:23];
          rb[22:0]  = ra[22:0] ^ 23'($urandom_range(0, 255));
          rb[31]    = ~ra[31];
        end
        if ($urandom_range(0, 1) == 1) begin tmp = ra; ra = rb; rb = tmp; end
      end
      do_op(ra, rb, 0, r_res, r_lat);
      ref_model(ra, rb, m_res, m_lat);
      chk("rand_result", r_res, m_res);
      chk("rand_latency", 32'(r_lat), 32'(m_lat));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
